// File: rtl/ha1588_pkg.sv
// Shared definitions for the ha1588 timestamp-queue reader.
// Holds the per-queue register offsets, the pop command word, the reader
// FSM state type and a helper that maps a data word index to its offset.
package ha1588_pkg;

    localparam logic [31:0] OFF_POP   = 32'h00;
    localparam logic [31:0] OFF_CNT   = 32'h04;
    localparam logic [31:0] OFF_DATA0 = 32'h08;
    localparam logic [31:0] OFF_DATA1 = 32'h0C;
    localparam logic [31:0] OFF_DATA2 = 32'h10;
    localparam logic [31:0] OFF_DATA3 = 32'h14;

    localparam logic [31:0] POP_CMD = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_CNT,
        ST_POP,
        ST_RD_W,
        ST_PUSH,
        ST_NEXTQ
    } tsq_state_t;

    function automatic logic [31:0] data_offset(input logic [1:0] k);
        logic [31:0] off;
        case (k)
            2'd0:    off = OFF_DATA0;
            2'd1:    off = OFF_DATA1;
            2'd2:    off = OFF_DATA2;
            default: off = OFF_DATA3;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/ha1588_wb_master_port.sv
// Single-access Wishbone classic master engine.
// A request sampled while idle launches one access; cyc/stb/we/adr/dat are
// registered and held until ack_i. done pulses combinationally on the ack
// cycle with rdata carrying dat_i, so the caller captures on that edge.
// If no ack arrives within TIMEOUT cycles the access is abandoned and
// timeout pulses instead; an ack on the last allowed cycle still wins.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req, we, addr,
//   wdata             : access request from the sequencer
//   done, rdata,
//   timeout           : completion status back to the sequencer
//   cyc_o .. ack_i    : Wishbone classic master bus
module ha1588_wb_master_port #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    logic        active;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [15:0] wait_cnt;

    // ack_i only counts while our strobe is up; stray acks are ignored.
    assign done    = active & ack_i;
    assign timeout = active & ~ack_i & (wait_cnt == 16'(TIMEOUT - 1));
    assign rdata   = dat_i;

    assign cyc_o = active;
    assign stb_o = active;
    assign we_o  = we_q;
    assign adr_o = adr_q;
    assign dat_o = dat_q;

    // Completion always returns to idle for one cycle, which guarantees the
    // gap between back-to-back accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            wait_cnt <= 16'h0;
        end else if (active) begin
            if (done || timeout) begin
                active   <= 1'b0;
                we_q     <= 1'b0;
                adr_q    <= 32'h0;
                dat_q    <= 32'h0;
                wait_cnt <= 16'h0;
            end else begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end else if (req) begin
            active   <= 1'b1;
            we_q     <= we;
            adr_q    <= addr;
            dat_q    <= wdata;
            wait_cnt <= 16'h0;
        end
    end

endmodule

// File: rtl/ha1588_wb_tsq_reader.sv
// Hardware poller for the ha1588 RX/TX timestamp queues.
// Every poll round reads the RX then the TX fill count, pops up to
// MAX_BURST entries per queue, reads the four data words of each entry and
// offers them on a 128-bit valid/ready stream tagged with the direction.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   enable, poll_period  : polling control; period 0 behaves as 1
//   cyc_o .. ack_i       : Wishbone classic master to the ha1588 slave
//   ts_valid, ts_ready,
//   ts_data, ts_dir      : timestamp stream ({w3,w2,w1,w0}, 0 = RX)
//   err_timeout          : sticky bus timeout flag
//   busy                 : a round is in progress
module ha1588_wb_tsq_reader
    import ha1588_pkg::*;
#(
    parameter logic [31:0] RX_BASE   = 32'h0000_0040,
    parameter logic [31:0] TX_BASE   = 32'h0000_0060,
    parameter int          MAX_BURST = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable,
    input  logic [15:0]  poll_period,
    output logic         cyc_o,
    output logic         stb_o,
    output logic         we_o,
    output logic [31:0]  adr_o,
    output logic [31:0]  dat_o,
    input  logic [31:0]  dat_i,
    input  logic         ack_i,
    output logic         ts_valid,
    input  logic         ts_ready,
    output logic [127:0] ts_data,
    output logic         ts_dir,
    output logic         err_timeout,
    output logic         busy
);

    tsq_state_t  state, state_nx;
    logic        dir;
    logic [7:0]  n;
    logic [1:0]  k;
    logic [15:0] poll_cnt;
    logic [15:0] poll_load;
    logic        req, we, done, timeout;
    logic [31:0] addr, wdata, rdata, base;
    logic [7:0]  fill;

    assign base      = dir ? TX_BASE : RX_BASE;
    assign poll_load = (poll_period == 16'd0) ? 16'd1 : poll_period;
    // Anything beyond the burst limit stays queued for a later round.
    assign fill      = (rdata[7:0] > 8'(MAX_BURST)) ? 8'(MAX_BURST) : rdata[7:0];

    assign ts_valid    = (state == ST_PUSH);
    assign ts_dir      = dir;
    assign busy        = (state != ST_IDLE) && (state != ST_WAIT);

    ha1588_wb_master_port #(.TIMEOUT(TIMEOUT)) u_port (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .done    (done),
        .rdata   (rdata),
        .timeout (timeout),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i)
    );

    // Bus request decode: the port ignores req while an access is in flight,
    // so holding req for the whole state launches exactly one access each
    // time the state (or k) moves on.
    always_comb begin
        req   = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        case (state)
            ST_RD_CNT: begin
                req  = 1'b1;
                addr = base + OFF_CNT;
            end
            ST_POP: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = base + OFF_POP;
                wdata = POP_CMD;
            end
            ST_RD_W: begin
                req  = 1'b1;
                addr = base + data_offset(k);
            end
            default: begin
            end
        endcase
    end

    // Next-state logic. Transitions fire on the ack cycle itself so the next
    // access can start after the port's mandatory single idle cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable)                  state_nx = ST_IDLE;
                else if (poll_cnt <= 16'd1)   state_nx = ST_RD_CNT;
            end
            ST_RD_CNT: begin
                if (timeout)                  state_nx = ST_IDLE;
                else if (done) begin
                    if (!enable)              state_nx = ST_IDLE;
                    else if (fill == 8'd0)    state_nx = ST_NEXTQ;
                    else                      state_nx = ST_POP;
                end
            end
            ST_POP: begin
                if (timeout)                  state_nx = ST_IDLE;
                else if (done)                state_nx = ST_RD_W;
            end
            ST_RD_W: begin
                if (timeout)                  state_nx = ST_IDLE;
                else if (done && k == 2'd3)   state_nx = ST_PUSH;
            end
            ST_PUSH: begin
                // A started entry always finishes; enable is only honoured here.
                if (ts_ready) begin
                    if (!enable)              state_nx = ST_IDLE;
                    else if (n == 8'd1)       state_nx = ST_NEXTQ;
                    else                      state_nx = ST_POP;
                end
            end
            ST_NEXTQ: begin
                if (!enable)                  state_nx = ST_IDLE;
                else if (!dir)                state_nx = ST_RD_CNT;
                else                          state_nx = ST_WAIT;
            end
            default:                          state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Datapath registers: poll counter, queue direction, burst and word
    // counters, the assembled entry and the sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir         <= 1'b0;
            n           <= 8'd0;
            k           <= 2'd0;
            poll_cnt    <= 16'd0;
            ts_data     <= 128'h0;
            err_timeout <= 1'b0;
        end else begin
            if (timeout) begin
                err_timeout <= 1'b1;
                ts_data     <= 128'h0;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) poll_cnt <= poll_load;
                end
                ST_WAIT: begin
                    poll_cnt <= poll_cnt - 16'd1;
                    dir      <= 1'b0;
                end
                ST_RD_CNT: begin
                    if (done) begin
                        n <= fill;
                        k <= 2'd0;
                    end
                end
                ST_POP: begin
                    if (done) k <= 2'd0;
                end
                ST_RD_W: begin
                    if (done) begin
                        ts_data[{k, 5'b00000} +: 32] <= rdata;
                        k <= k + 2'd1;
                    end
                end
                ST_PUSH: begin
                    if (ts_ready) n <= n - 8'd1;
                end
                ST_NEXTQ: begin
                    if (!dir) dir      <= 1'b1;
                    else      poll_cnt <= poll_load;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ha1588_wb_tsq_reader.sv
// Directed self-checking bench for ha1588_wb_tsq_reader.
// A behavioural ha1588 slave (RX/TX queues with data windows) answers the
// bus on the falling edge; a monitor in the same process records stream
// handshakes and timing marks that the directed steps then check.
module tb_ha1588_wb_tsq_reader;

    localparam logic [31:0] RX_BASE = 32'h0000_0040;
    localparam logic [31:0] TX_BASE = 32'h0000_0060;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable;
    logic [15:0]  poll_period;
    logic         cyc_o, stb_o, we_o;
    logic [31:0]  adr_o, dat_o;
    logic [31:0]  dat_i = 32'h0;
    logic         ack_i = 1'b0;
    logic         ts_valid;
    logic         ts_ready;
    logic [127:0] ts_data;
    logic         ts_dir;
    logic         err_timeout;
    logic         busy;

    always #5 clk_i = ~clk_i;

    ha1588_wb_tsq_reader dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable      (enable),
        .poll_period (poll_period),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .ack_i       (ack_i),
        .ts_valid    (ts_valid),
        .ts_ready    (ts_ready),
        .ts_data     (ts_data),
        .ts_dir      (ts_dir),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [127:0] rxq[$];
    logic [127:0] txq[$];
    logic [127:0] rx_win = 128'h0;
    logic [127:0] tx_win = 128'h0;
    logic [128:0] cap[$];

    int ncyc = 0, wait_left = -1, b2b_viol = 0;
    int rx_pops = 0, tx_pops = 0, tx_cnt_reads = 0, valid_cycles = 0;
    int last_cnt_ack = 0, last_w3_ack = 0, last_pop_lat = -1, last_present_lat = -1;
    logic [7:0]  last_tx_cnt = 8'hFF;
    bit          pop_pending = 1'b0, prev_valid = 1'b0, rand_waits = 1'b0, stall_en = 1'b0;
    logic [31:0] stall_addr = 32'h0;
    bit          s_tx;
    logic [31:0] s_off;
    int          s_fill, s_word;

    // Slave model and stream monitor, evaluated on the falling edge so the
    // DUT's registered outputs are settled and ack lands on the next rise.
    always @(negedge clk_i) begin
        ncyc++;
        if (cyc_o && ack_i) b2b_viol++;
        if (ts_valid && !prev_valid) last_present_lat = ncyc - last_w3_ack;
        prev_valid = ts_valid;
        if (ts_valid) valid_cycles++;
        if (ts_valid && ts_ready) cap.push_back({ts_dir, ts_data});
        if (cyc_o && stb_o && !ack_i) begin
            if (wait_left < 0) begin
                wait_left = rand_waits ? int'($urandom_range(3, 0)) : 0;
                if (we_o && pop_pending) begin
                    last_pop_lat = ncyc - last_cnt_ack;
                    pop_pending  = 1'b0;
                end
            end
            if (!(stall_en && adr_o == stall_addr)) begin
                if (wait_left == 0) begin
                    ack_i     = 1'b1;
                    wait_left = -1;
                    s_tx      = (adr_o >= TX_BASE);
                    s_off     = adr_o - (s_tx ? TX_BASE : RX_BASE);
                    dat_i     = 32'h0;
                    if (we_o) begin
                        if (s_off == 32'h0 && dat_o == 32'h1) begin
                            if (s_tx && txq.size() > 0) begin
                                tx_win = txq.pop_front();
                                tx_pops++;
                            end else if (!s_tx && rxq.size() > 0) begin
                                rx_win = rxq.pop_front();
                                rx_pops++;
                            end
                        end
                    end else if (s_off == 32'h4) begin
                        s_fill       = s_tx ? txq.size() : rxq.size();
                        dat_i        = 32'(s_fill);
                        last_cnt_ack = ncyc;
                        pop_pending  = (s_fill > 0);
                        if (s_tx) begin
                            tx_cnt_reads++;
                            last_tx_cnt = 8'(s_fill);
                        end
                    end else if (s_off >= 32'h8 && s_off <= 32'h14) begin
                        s_word = int'((s_off - 32'h8) >> 2);
                        dat_i  = s_tx ? tx_win[32*s_word +: 32] : rx_win[32*s_word +: 32];
                        if (s_word == 3) last_w3_ack = ncyc;
                    end
                end else begin
                    wait_left--;
                end
            end
        end else begin
            ack_i     = 1'b0;
            dat_i     = 32'h0;
            wait_left = -1;
        end
    end

    function automatic logic [127:0] mk(input logic d, input int i);
        logic [7:0] t;
        t = d ? 8'hB0 : 8'hA0;
        return {t | 8'h3, 24'(i), t | 8'h2, 24'(i), t | 8'h1, 24'(i), t, 24'(i)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [15:0] period, input logic rdy);
        enable      = en;
        poll_period = period;
        ts_ready    = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitCaptures(input int want, input int budget, input string tag);
        int c = 0;
        while (cap.size() < want && c < budget) begin
            tick(1);
            c++;
        end
        checkOutput(tag, 160'(cap.size()), 160'(want));
    endtask

    task automatic settleIdle(input string tag);
        int c = 0;
        enable = 1'b0;
        tick(1);
        while ((busy || cyc_o) && c < 500) begin
            tick(1);
            c++;
        end
        tick(3);
        checkOutput(tag, {busy, cyc_o}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    localparam logic [127:0] ENT_A = 128'h1111_0003_1111_0002_1111_0001_1111_0000;
    localparam logic [127:0] ENT_B = 128'h2222_0003_2222_0002_2222_0001_2222_0000;
    localparam logic [127:0] ENT_C = 128'hC0FF_EE03_C0FF_EE02_C0FF_EE01_C0FF_EE00;
    localparam logic [127:0] ENT_D = 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000;

    initial begin
        int c, cnt, bad, base_pops, base_valid;
        int ord_dir[15];
        int ord_idx[15];
        logic [127:0] snap;
        logic [128:0] obs;
        logic reached;

        ord_dir = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0};
        ord_idx = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 8};

        // Reset: every output must read zero.
        rst_i = 1'b1;
        applyStimulus(1'b0, 16'd0, 1'b0);
        tick(3);
        checkOutput("reset_bus", {cyc_o, stb_o, we_o, adr_o, dat_o}, 67'h0);
        checkOutput("reset_stream", {ts_valid, ts_dir, err_timeout, busy, ts_data}, 132'h0);
        rst_i = 1'b0;
        tick(1);

        // Two RX entries, zero-wait slave, consumer always ready.
        $display("[TB] step 1: RX count 2, zero-wait slave");
        rxq.push_back(ENT_A);
        rxq.push_back(ENT_B);
        applyStimulus(1'b1, 16'd4, 1'b1);
        waitCaptures(2, 400, "t1_captures");
        obs = (cap.size() > 0) ? cap[0] : 'x;
        checkOutput("t1_entry_A", obs, {1'b0, ENT_A});
        obs = (cap.size() > 1) ? cap[1] : 'x;
        checkOutput("t1_entry_B", obs, {1'b0, ENT_B});
        checkOutput("t1_pop_latency", 160'(last_pop_lat), 160'd2);
        checkOutput("t1_present_latency", 160'(last_present_lat), 160'd1);
        c = 0;
        while (tx_cnt_reads < 1 && c < 200) begin
            tick(1);
            c++;
        end
        checkOutput("t1_tx_count_zero", {8'(tx_cnt_reads), last_tx_cnt}, {8'd1, 8'd0});
        tick(2);
        checkOutput("t1_back_to_wait", {busy, cyc_o}, 2'b00);
        checkOutput("t1_pops", {16'(rx_pops), 16'(tx_pops)}, {16'd2, 16'd0});
        settleIdle("t1_settle");

        // RX 9 / TX 6 with burst limit 4: three rounds, both queues per round.
        $display("[TB] step 2: burst-limited draining over three rounds");
        cap.delete();
        for (int i = 0; i < 9; i++) rxq.push_back(mk(1'b0, i));
        for (int i = 0; i < 6; i++) txq.push_back(mk(1'b1, i));
        applyStimulus(1'b1, 16'd0, 1'b1);
        waitCaptures(15, 3000, "t2_captures");
        for (int i = 0; i < 15; i++) begin
            obs = (i < cap.size()) ? cap[i] : 'x;
            checkOutput($sformatf("t2_order_%0d", i), obs,
                        {ord_dir[i][0], mk(ord_dir[i][0], ord_idx[i])});
        end
        settleIdle("t2_settle");

        // Back-pressure: consumer stalls 50 cycles in PUSH.
        $display("[TB] step 3: consumer back-pressure");
        cap.delete();
        rxq.push_back(ENT_C);
        applyStimulus(1'b1, 16'd2, 1'b0);
        c = 0;
        while (!ts_valid && c < 300) begin
            tick(1);
            c++;
        end
        checkOutput("t3_valid_reached", ts_valid, 1'b1);
        snap = ts_data;
        bad  = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (!ts_valid || ts_data !== snap || cyc_o) bad++;
        end
        checkOutput("t3_stall_hold", 160'(bad), 160'd0);
        ts_ready = 1'b1;
        waitCaptures(1, 20, "t3_release");
        checkOutput("t3_valid_drop", ts_valid, 1'b0);
        obs = (cap.size() > 0) ? cap[0] : 'x;
        checkOutput("t3_entry_C", obs, {1'b0, ENT_C});
        settleIdle("t3_settle");

        // Slave never acks data word 2: access aborted after 255 cycles.
        $display("[TB] step 4: bus timeout on data word 2");
        cap.delete();
        base_valid = valid_cycles;
        rxq.push_back(ENT_D);
        stall_addr = RX_BASE + 32'h10;
        stall_en   = 1'b1;
        applyStimulus(1'b1, 16'd2, 1'b1);
        c = 0;
        while (!(cyc_o && adr_o == stall_addr) && c < 300) begin
            tick(1);
            c++;
        end
        cnt = 0;
        while (cyc_o && adr_o == stall_addr && cnt < 400) begin
            cnt++;
            tick(1);
        end
        checkOutput("t4_timeout_len", 160'(cnt), 160'd255);
        checkOutput("t4_err_set", {err_timeout, cyc_o}, 2'b10);
        tick(2);
        settleIdle("t4_settle");
        stall_en = 1'b0;
        checkOutput("t4_no_entry", {16'(valid_cycles - base_valid), 16'(cap.size())}, 32'h0);
        checkOutput("t4_err_sticky", err_timeout, 1'b1);

        // Random wait states; enable drops while an entry is being read.
        $display("[TB] step 5: enable dropped mid-entry, reset mid-read");
        cap.delete();
        rand_waits = 1'b1;
        rxq.push_back(mk(1'b0, 100));
        rxq.push_back(mk(1'b0, 101));
        rxq.push_back(mk(1'b0, 102));
        base_pops = rx_pops;
        applyStimulus(1'b1, 16'd3, 1'b1);
        c = 0;
        while (rx_pops == base_pops && c < 500) begin
            tick(1);
            c++;
        end
        enable = 1'b0;
        waitCaptures(1, 500, "t5_entry_done");
        obs = (cap.size() > 0) ? cap[0] : 'x;
        checkOutput("t5_entry_E0", obs, {1'b0, mk(1'b0, 100)});
        tick(100);
        checkOutput("t5_no_more_pops", {16'(rx_pops - base_pops), 16'(cap.size())}, {16'd1, 16'd1});
        checkOutput("t5_idle", {busy, cyc_o}, 2'b00);

        // Synchronous reset pulse in the middle of a data-word read.
        enable = 1'b1;
        c = 0;
        reached = 1'b0;
        while (!reached && c < 500) begin
            tick(1);
            c++;
            reached = cyc_o && !we_o && adr_o >= RX_BASE + 32'h8 && adr_o <= RX_BASE + 32'h14;
        end
        checkOutput("t5_read_reached", reached, 1'b1);
        rst_i = 1'b1;
        tick(1);
        checkOutput("t5_rst_bus", {cyc_o, stb_o, we_o, adr_o, dat_o}, 67'h0);
        checkOutput("t5_rst_stream", {ts_valid, ts_dir, err_timeout, busy, ts_data}, 132'h0);
        rst_i  = 1'b0;
        enable = 1'b0;
        tick(3);

        checkOutput("no_back_to_back", 160'(b2b_viol), 160'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ha1588_wb_tsq_reader.md
Name: ha1588_wb_tsq_reader

Overview:
- Wishbone classic master directly upstream of the ha1588_wb slave port.
- Periodically polls the RX and TX timestamp-queue fill counts and pops queued entries.
- Reads each 4-word timestamp and presents it as a 128-bit valid/ready stream to the host-side consumer (DMA or CPU mailbox).
- Replaces software polling of the TSU queues.

Parameters:
- RX_BASE, 32'h0000_0040, byte base of the RX queue register group.
- TX_BASE, 32'h0000_0060, byte base of the TX queue register group.
- Register group layout: +0x00 pop control (write 32'h1 = pop head into the data window); +0x04 fill count (bits [7:0]); +0x08..+0x14 data words 0..3.
- MAX_BURST, 4, maximum entries drained per queue per poll round (1..255).
- TIMEOUT, 255, cycles without ack_i before a bus access is aborted.

Ports:
- clk_i in 1: the single clock.
- rst_i in 1: synchronous, active-high reset.
- enable in 1: 1 = polling active; 0 = finish the current entry, then idle.
- poll_period in 16: idle cycles between poll rounds; 0 is treated as 1.
- cyc_o out 1: Wishbone cycle.
- stb_o out 1: Wishbone strobe.
- we_o out 1: Wishbone write enable.
- adr_o out 32: byte address.
- dat_o out 32: write data.
- dat_i in 32: read data.
- ack_i in 1: slave acknowledge.
- ts_valid out 1: timestamp entry available.
- ts_ready in 1: consumer accepts the entry.
- ts_data out 128: {word3,word2,word1,word0}.
- ts_dir out 1: 0 = RX, 1 = TX.
- err_timeout out 1: sticky bus-timeout flag; cleared by rst_i only.
- busy out 1: FSM not in IDLE or WAIT.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; poll counter 0; ts_data 0.
- Bus access:
  - cyc_o, stb_o, we_o, adr_o and dat_o assert together and hold until the cycle ack_i = 1.
  - Read data is captured on the ack cycle.
  - cyc_o and stb_o drop the next cycle. At least one idle cycle separates consecutive accesses.
  - ack_i while stb_o = 0 is ignored.
- FSM states:
  - IDLE: if enable = 1, load the poll counter from poll_period and go to WAIT.
  - WAIT: decrement the counter each cycle. At 0, set dir = RX and go to RD_CNT.
  - RD_CNT: read base+0x04. On ack, n = min(dat_i[7:0], MAX_BURST). If n = 0, go to NEXTQ; otherwise go to POP.
  - POP: write 32'h1 to base+0x00, then go to RD_W with word index k = 0.
  - RD_W: read base+0x08+4k into word k. After k = 3, go to PUSH.
  - PUSH: ts_valid = 1 with ts_data and ts_dir stable. On ts_valid & ts_ready, ts_valid drops the next cycle, n decrements, and the FSM goes to POP if n ≠ 0, else NEXTQ.
  - NEXTQ: if dir = RX, set dir = TX and go to RD_CNT; otherwise go to IDLE (or straight to WAIT if enable = 1).
- Latency: first pop-data access starts 2 cycles after RD_CNT ack with a zero-wait slave. The entry is presented at the earliest 1 cycle after the word-3 ack.
- Back-pressure: PUSH may stall indefinitely; no bus activity occurs while stalled.
- Timeout: in any bus state, if ack_i is absent for TIMEOUT consecutive cycles:
  - drop cyc_o and stb_o;
  - set err_timeout = 1;
  - discard the partial entry;
  - go to IDLE.
  - ack_i arriving exactly on the TIMEOUT-th cycle counts as success.
- enable deasserted mid-round: the current entry completes through PUSH, then the FSM returns to IDLE without further pops.
- A fill count above 255 is not possible (8-bit field). A count larger than MAX_BURST is drained on later rounds.
- rst_i asserted mid-transfer: all outputs are 0 on the next cycle. A half-read entry is lost; software resynchronises the queue.

Decomposition:
- Shared package ha1588_pkg: register offsets (POP, CNT, DATA0..3), POP_CMD = 32'h1, FSM state enum.
- One sub-module, ha1588_wb_master_port: single-access Wishbone engine with its own timeout counter. Interface: req, we, addr, wdata → done, rdata, timeout.

Test Plan:
- Zero-wait slave model, RX count 2, entries A/B, ts_ready = 1 → two RX outputs with exact 128-bit values; TX count read 0; returns to WAIT.
- RX count 9, MAX_BURST = 4 → 4 entries in round 1, 4 in round 2, 1 in round 3; TX serviced in each round.
- ts_ready held 0 for 50 cycles during PUSH → ts_valid held with data stable; cyc_o = 0 throughout; one entry delivered on release.
- Slave withholds ack on word 2 → cyc_o drops after 255 cycles; err_timeout = 1; no ts_valid.
- Random 0–3 wait states, enable dropped mid-entry → entry completes, FSM goes to IDLE; rst_i pulse mid-read → all outputs 0 next cycle.
